// File: rtl/serial_adder_if.sv
// Handshake and data bundle between a requester and the bit-serial adder.
// The master side issues operands and start; the slave side returns status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start,
    output a,
    output b,
    output cin,
    input  busy,
    input  done,
    input  sum,
    input  cout
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  cin,
    output busy,
    output done,
    output sum,
    output cout
  );

endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell is reused for WIDTH cycles.
// Operands shift out LSB first, sum bits shift in at the MSB, and the carry
// is fed back through a flip-flop. The result is published on a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             c_ff;
  logic [CW-1:0]    cnt;
  // Holds the WIDTH-1 sum bits collected so far; the final bit is joined on the last edge.
  logic [WIDTH-2:0] r_sh;
  logic [WIDTH-1:0] r_ext;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic load;
  logic last;
  logic fa_sum;
  logic fa_carry;

  // The shared full-adder cell working on the current LSBs and the stored carry.
  always_comb begin
    fa_sum   = a_sh[0] ^ b_sh[0] ^ c_ff;
    fa_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & c_ff) | (b_sh[0] & c_ff);
    r_ext    = {fa_sum, r_sh};
  end

  // State register; reset returns to IDLE and discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; the DONE->IDLE edge also accepts a start so a held start repeats every WIDTH+1 cycles.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_BIT) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand shifters, carry feedback, bit counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      c_ff   <= 1'b0;
      cnt    <= '0;
      r_sh   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (load) begin
      a_sh <= bus.a;
      b_sh <= bus.b;
      c_ff <= bus.cin;
      cnt  <= '0;
      r_sh <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      c_ff <= fa_carry;
      r_sh <= r_ext[WIDTH-1:1];
      if (last) begin
        cnt    <= '0;
        sum_q  <= r_ext;
        cout_q <= fa_carry;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Status flags are registered from the next state so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_next == RUN);
      done_q <= (state_next == DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, hand-written corner
// sequences, random operands against an arithmetic model, and an exhaustive
// sweep of a 4-bit instance.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    bit         poke;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_sum;
  logic       exp_cout;

  // Advance one clock and land just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Runs one 8-bit add from IDLE and checks latency, busy span, result hold and the result.
  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input bit poke,
                               input logic [7:0] want_sum, input logic want_cout);
    int lat;
    int busy_cnt;
    bit held;
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = cin;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    held     = 1'b1;
    while (!bus8.done && lat < 20) begin
      if (bus8.busy) busy_cnt++;
      if (bus8.sum !== exp_sum || bus8.cout !== exp_cout) held = 1'b0;
      if (poke && (lat == 2 || lat == 5)) begin
        bus8.start = 1'b1;
        bus8.a     = 8'h00;
        bus8.b     = 8'h00;
        bus8.cin   = 1'b0;
      end else begin
        bus8.start = 1'b0;
      end
      step();
      lat++;
    end
    bus8.start = 1'b0;
    checkOutput({tag, " latency"}, lat, 8);
    checkOutput({tag, " busy_cycles"}, busy_cnt, 8);
    checkOutput({tag, " sum_held"}, held, 1);
    checkOutput({tag, " busy_at_done"}, bus8.busy, 0);
    checkOutput({tag, " sum"}, bus8.sum, want_sum);
    checkOutput({tag, " cout"}, bus8.cout, want_cout);
    exp_sum  = want_sum;
    exp_cout = want_cout;
    step();
    checkOutput({tag, " done_single"}, bus8.done, 0);
    checkOutput({tag, " idle_after"}, bus8.busy, 0);
  endtask

  vec_t vecs[$];

  // Global time bound so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int dones[$];
    int stale;
    int bad4;
    int lat4_bad;
    bit b2b_sum_ok;
    logic [8:0] total;
    logic [4:0] total4;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;

    vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0});
    vecs.push_back('{8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hC3, 8'h3C, 1'b0, 1'b0, 8'hFF, 1'b0});

    rst        = 1'b1;
    bus8.start = 1'b0;
    bus8.a     = 8'h00;
    bus8.b     = 8'h00;
    bus8.cin   = 1'b0;
    bus4.start = 1'b0;
    bus4.a     = 4'h0;
    bus4.b     = 4'h0;
    bus4.cin   = 1'b0;
    exp_sum    = 8'h00;
    exp_cout   = 1'b0;
    step();
    step();
    checkOutput("reset busy", bus8.busy, 0);
    checkOutput("reset done", bus8.done, 0);
    checkOutput("reset sum", bus8.sum, 0);
    checkOutput("reset cout", bus8.cout, 0);
    rst = 1'b0;
    step();

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                    vecs[i].poke, vecs[i].exp_sum, vecs[i].exp_cout);
    end

    // Reset and start on the same edge: reset wins
    rst        = 1'b1;
    bus8.start = 1'b1;
    bus8.a     = 8'h11;
    bus8.b     = 8'h22;
    step();
    rst        = 1'b0;
    bus8.start = 1'b0;
    exp_sum    = 8'h00;
    exp_cout   = 1'b0;
    checkOutput("rst_start busy", bus8.busy, 0);
    checkOutput("rst_start sum", bus8.sum, 0);
    step();
    checkOutput("rst_start not_accepted", bus8.busy, 0);

    // Reset in the middle of a run
    applyStimulus("pre_abort", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);
    bus8.a     = 8'hAA;
    bus8.b     = 8'h55;
    bus8.cin   = 1'b0;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("abort busy", bus8.busy, 0);
    checkOutput("abort done", bus8.done, 0);
    checkOutput("abort sum", bus8.sum, 0);
    checkOutput("abort cout", bus8.cout, 0);
    exp_sum  = 8'h00;
    exp_cout = 1'b0;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus8.done || bus8.busy) stale++;
      step();
    end
    checkOutput("abort no_stale_activity", stale, 0);
    applyStimulus("post_abort", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);

    // Start held high: back-to-back operations
    bus8.a     = 8'h10;
    bus8.b     = 8'h20;
    bus8.cin   = 1'b0;
    bus8.start = 1'b1;
    b2b_sum_ok = 1'b1;
    for (int t = 0; t < 40; t++) begin
      step();
      if (bus8.done) begin
        dones.push_back(t);
        if (bus8.sum !== 8'h30 || bus8.cout !== 1'b0) b2b_sum_ok = 1'b0;
      end
    end
    bus8.start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    checkOutput("b2b done_count", (dones.size() >= 4), 1);
    checkOutput("b2b sum", b2b_sum_ok, 1);
    for (int i = 1; i < dones.size(); i++) begin
      checkOutput($sformatf("b2b interval%0d", i), dones[i] - dones[i-1], 9);
    end
    exp_sum  = 8'h30;
    exp_cout = 1'b0;

    // Random operands against plain arithmetic
    for (int i = 0; i < 40; i++) begin
      ra    = 8'($urandom_range(0, 255));
      rb    = 8'($urandom_range(0, 255));
      rc    = 1'($urandom_range(0, 1));
      total = 9'(int'(ra) + int'(rb) + int'(rc));
      applyStimulus($sformatf("rand%0d", i), ra, rb, rc, 1'b0, total[7:0], total[8]);
    end

    // Exhaustive sweep of the 4-bit instance
    bad4     = 0;
    lat4_bad = 0;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          int lat;
          bus4.a     = 4'(ia);
          bus4.b     = 4'(ib);
          bus4.cin   = 1'(ic);
          bus4.start = 1'b1;
          step();
          bus4.start = 1'b0;
          lat = 0;
          while (!bus4.done && lat < 10) begin
            step();
            lat++;
          end
          if (lat != 4) lat4_bad++;
          total4 = 5'(ia + ib + ic);
          tests++;
          if ({bus4.cout, bus4.sum} !== total4) begin
            fails++;
            bad4++;
            if (bad4 <= 5)
              $display("[TB] FAIL w4 a=%0h b=%0h cin=%0d: got 0x%0h expected 0x%0h",
                       ia, ib, ic, {bus4.cout, bus4.sum}, total4);
          end
          step();
        end
      end
    end
    checkOutput("w4 latency_errors", lat4_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
